// File: rtl/text_buffer.sv
// Character-cell text buffer: pixel-coordinate read pipeline (2-cycle latency)
// and a terminal-style writer. Optional blinking cursor overlay: TEXT_CURSOR_EN.
module text_buffer #(
    parameter int         COLS     = 60,
    parameter int         ROWS     = 34,
    parameter logic [7:0] FILL_CHR = 8'h20,
    parameter int         BLINK_W  = 22
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [8:0] i_x,
    input  logic [8:0] i_y,
    output logic [7:0] o_chr,
    input  logic       i_wr_valid,
    input  logic [7:0] i_wr_data,
    output logic       o_wr_ready,
    output logic [5:0] o_cur_col,
    output logic [5:0] o_cur_row,
    output logic       o_busy
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [5:0]  COLS_L    = 6'(COLS);
    localparam logic [5:0]  ROWS_L    = 6'(ROWS);
    localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
    localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
    localparam logic [10:0] LAST_ADDR = 11'(CELLS - 1);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        CLRROW
    } state_t;

    function automatic logic [10:0] cell_addr(input logic [5:0] row, input logic [5:0] col);
        return 11'(row) * 11'(COLS) + 11'(col);
    endfunction

    // ------------------------------------------------------------------
    // Character RAM: one write port, one registered read port
    // ------------------------------------------------------------------
    logic [7:0]  mem [0:CELLS-1];
    logic [7:0]  ram_q;
    logic        ram_we;
    logic [10:0] ram_waddr;
    logic [10:0] ram_raddr;
    logic [7:0]  ram_wdata;

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_q <= mem[ram_raddr];
    end

    // ------------------------------------------------------------------
    // Writer FSM
    // ------------------------------------------------------------------
    state_t      state;
    logic [10:0] clr_addr;
    logic [5:0]  clr_col;
    logic        xfer;
    logic        printable;
    logic [5:0]  next_row;

    assign xfer      = i_wr_valid && o_wr_ready && (state == IDLE);
    assign printable = (i_wr_data >= 8'h20) && (i_wr_data <= 8'h7E);
    assign next_row  = (o_cur_row == LAST_ROW) ? 6'd0 : o_cur_row + 6'd1;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr;
        ram_wdata = FILL_CHR;
        case (state)
            CLEAR: begin
                ram_we = 1'b1;
            end
            CLRROW: begin
                ram_we    = 1'b1;
                ram_waddr = cell_addr(o_cur_row, clr_col);
            end
            IDLE: begin
                if (xfer && printable) begin
                    ram_we    = 1'b1;
                    ram_waddr = cell_addr(o_cur_row, o_cur_col);
                    ram_wdata = i_wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            clr_col    <= '0;
            o_cur_col  <= '0;
            o_cur_row  <= '0;
            o_wr_ready <= 1'b0;
            o_busy     <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        clr_addr   <= '0;
                        o_cur_col  <= '0;
                        o_cur_row  <= '0;
                        o_wr_ready <= 1'b1;
                        o_busy     <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 11'd1;
                    end
                end
                IDLE: begin
                    if (xfer) begin
                        if (printable) begin
                            if (o_cur_col == LAST_COL) begin
                                // column wrap doubles as a row advance
                                o_cur_col  <= '0;
                                o_cur_row  <= next_row;
                                clr_col    <= '0;
                                state      <= CLRROW;
                                o_wr_ready <= 1'b0;
                            end else begin
                                o_cur_col <= o_cur_col + 6'd1;
                            end
                        end else begin
                            case (i_wr_data)
                                8'h0D: o_cur_col <= '0;
                                8'h0A: begin
                                    o_cur_row  <= next_row;
                                    clr_col    <= '0;
                                    state      <= CLRROW;
                                    o_wr_ready <= 1'b0;
                                end
                                8'h08: begin
                                    if (o_cur_col != 6'd0) begin
                                        o_cur_col <= o_cur_col - 6'd1;
                                    end
                                end
                                8'h0C: begin
                                    o_cur_col  <= '0;
                                    o_cur_row  <= '0;
                                    clr_addr   <= '0;
                                    state      <= CLEAR;
                                    o_wr_ready <= 1'b0;
                                    o_busy     <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLRROW: begin
                    if (clr_col == LAST_COL) begin
                        state      <= IDLE;
                        o_wr_ready <= 1'b1;
                    end else begin
                        clr_col <= clr_col + 6'd1;
                    end
                end
                default: begin
                    state      <= CLEAR;
                    clr_addr   <= '0;
                    o_wr_ready <= 1'b0;
                    o_busy     <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    logic [5:0] pix_col;
    logic [5:0] pix_row;
    logic       pix_oor;
    logic       fill_reg;

    assign pix_col   = i_x[8:3];
    assign pix_row   = i_y[8:3];
    assign pix_oor   = (pix_col >= COLS_L) || (pix_row >= ROWS_L);
    assign ram_raddr = pix_oor ? 11'd0 : cell_addr(pix_row, pix_col);

`ifdef TEXT_CURSOR_EN
    logic [BLINK_W-1:0] blink_reg;
    logic               hit_reg;
    logic               unused_bits;

    assign unused_bits = ^{i_x[2:0], i_y[2:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_reg <= '0;
        end else begin
            blink_reg <= blink_reg + BLINK_W'(1);
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{i_x[2:0], i_y[2:0], 1'(BLINK_W)};
`endif

    // Cells read while the screen is still being cleared are masked to the
    // fill code, so o_chr never reflects uninitialised RAM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fill_reg <= 1'b1;
            o_chr    <= FILL_CHR;
`ifdef TEXT_CURSOR_EN
            hit_reg  <= 1'b0;
`endif
        end else begin
            fill_reg <= pix_oor || (state == CLEAR);
`ifdef TEXT_CURSOR_EN
            hit_reg  <= (pix_col == o_cur_col) && (pix_row == o_cur_row) && blink_reg[BLINK_W-1];
            o_chr    <= fill_reg ? FILL_CHR : (hit_reg ? 8'h5F : ram_q);
`else
            o_chr    <= fill_reg ? FILL_CHR : ram_q;
`endif
        end
    end

endmodule

// File: tb/tb_text_buffer.sv
// Randomized bench for text_buffer: a screen-array reference model drives the
// expected cursor, stall lengths and cell contents.
module tb_text_buffer;

    localparam int COLS = 60;
    localparam int ROWS = 34;
    localparam int CLEAR_CYCLES = COLS * ROWS;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [8:0] i_x = '0;
    logic [8:0] i_y = '0;
    logic [7:0] o_chr;
    logic       i_wr_valid = 1'b0;
    logic [7:0] i_wr_data = '0;
    logic       o_wr_ready;
    logic [5:0] o_cur_col;
    logic [5:0] o_cur_row;
    logic       o_busy;

    text_buffer dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_x        (i_x),
        .i_y        (i_y),
        .o_chr      (o_chr),
        .i_wr_valid (i_wr_valid),
        .i_wr_data  (i_wr_data),
        .o_wr_ready (o_wr_ready),
        .o_cur_col  (o_cur_col),
        .o_cur_row  (o_cur_row),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // reference model: screen contents and cursor
    logic [7:0] scr [ROWS][COLS];
    int mcol = 0;
    int mrow = 0;
    int px = 0;
    int py = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
    endtask

    function automatic logic [7:0] model_read(input int x, input int y);
        int c = x / 8;
        int r = y / 8;
        if (c >= COLS || r >= ROWS) return 8'h20;
        return scr[r][c];
    endfunction

    task automatic model_advance(output int stall);
        mrow = (mrow + 1) % ROWS;
        for (int c = 0; c < COLS; c++) scr[mrow][c] = 8'h20;
        stall = COLS;
    endtask

    // applies one consumed byte; returns how many cycles ready should stay low
    task automatic model_apply(input logic [7:0] b, output int stall);
        stall = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow][mcol] = b;
            mcol++;
            if (mcol == COLS) begin
                mcol = 0;
                model_advance(stall);
            end
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            model_advance(stall);
        end else if (b == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (b == 8'h0C) begin
            model_clear();
            mcol = 0;
            mrow = 0;
            stall = CLEAR_CYCLES;
        end
    endtask

    task automatic wait_ready(output int n, output int busy_bad);
        n = 0;
        busy_bad = 0;
        while (o_wr_ready !== 1'b1 && n < 5000) begin
            @(posedge i_clk);
            #1;
            n++;
            if (o_wr_ready !== 1'b1 && o_busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int stall;
        int n;
        int bb;
        @(negedge i_clk);
        i_wr_valid = 1'b1;
        i_wr_data  = b;
        @(posedge i_clk);
        #1;
        i_wr_valid = 1'b0;
        model_apply(b, stall);
        wait_ready(n, bb);
        check("stall", n, stall);
        check("cur_col", o_cur_col, mcol);
        check("cur_row", o_cur_row, mrow);
        $display("tx data=%02h col=%0d row=%0d stall=%0d", b, o_cur_col, o_cur_row, n);
    endtask

    task automatic read_cell(input int x, input int y);
        logic [7:0] prev;
        logic [7:0] exp;
        @(posedge i_clk);
        prev = model_read(px, py);
        exp  = model_read(x, y);
        @(negedge i_clk);
        i_x = 9'(x);
        i_y = 9'(y);
        px = x;
        py = y;
        @(posedge i_clk);
        #1;
        check("chr_lat1", o_chr, prev);
        @(posedge i_clk);
        #1;
        check("chr", o_chr, exp);
    endtask

    task automatic sweep();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                read_cell(c * 8 + $urandom_range(0, 7), r * 8 + $urandom_range(0, 7));
    endtask

    task automatic check_reset_state();
        check("rst_chr", o_chr, 8'h20);
        check("rst_ready", o_wr_ready, 1'b0);
        check("rst_busy", o_busy, 1'b1);
        check("rst_col", o_cur_col, 6'd0);
        check("rst_row", o_cur_row, 6'd0);
    endtask

    task automatic release_and_clear();
        int n;
        int bb;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_ready(n, bb);
        check("clear_cycles", n, CLEAR_CYCLES);
        check("busy_in_clear", bb, 0);
        check("busy_after_clear", o_busy, 1'b0);
        model_clear();
        mcol = 0;
        mrow = 0;
    endtask

    function automatic logic [7:0] rand_byte();
        int k = $urandom_range(0, 99);
        logic [7:0] b;
        if (k < 74) b = 8'($urandom_range(32, 126));
        else if (k < 82) b = 8'h0A;
        else if (k < 88) b = 8'h0D;
        else if (k < 93) b = 8'h08;
        else if (k < 97) begin
            b = 8'($urandom_range(0, 31));
            if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h07;
        end else b = 8'($urandom_range(127, 255));
        return b;
    endfunction

    initial begin
        logic [7:0] old;
        int cx;
        int cy;
        int stall;
        int n;
        int bb;

        model_clear();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_state();
        release_and_clear();
        sweep();

        // "Hi" then fill the rest of row 0 to force a wrap
        send(8'h48);
        send(8'h69);
        check("hi_col", o_cur_col, 6'd2);
        check("hi_row", o_cur_row, 6'd0);
        read_cell(8, 0);
        check("hi_i", o_chr, 8'h69);
        read_cell(0, 0);
        check("hi_h", o_chr, 8'h48);
        for (int i = 2; i < COLS; i++) send(8'($urandom_range(33, 126)));
        check("wrap_col", o_cur_col, 6'd0);
        check("wrap_row", o_cur_row, 6'd1);
        read_cell(0, 8);
        check("wrap_cell", o_chr, 8'h20);

        for (int i = 0; i < 400; i++) send(rand_byte());
        sweep();

        // bottom-row wrap with data preserved on row 1
        send(8'h0D);
        while (mrow != 1) send(8'h0A);
        send(8'h41);
        send(8'h42);
        while (mrow != ROWS - 1) send(8'h0A);
        send(8'h0A);
        check("lf_wrap_row", o_cur_row, 6'd0);
        send(8'h0D);
        send(8'h08);
        send(8'h07);
        check("ctl_col", o_cur_col, 6'd0);
        check("ctl_row", o_cur_row, 6'd0);
        sweep();

        // off-screen reads
        read_cell(480, 0);
        check("oor_x", o_chr, 8'h20);
        read_cell(0, 272);
        check("oor_y", o_chr, 8'h20);
        read_cell(511, 511);
        for (int i = 0; i < 60; i++) read_cell($urandom_range(0, 511), $urandom_range(0, 511));

        // read and write the same cell in the same cycle
        for (int i = 0; i < 3; i++) send(8'($urandom_range(33, 126)));
        cx = mcol * 8;
        cy = mrow * 8;
        old = model_read(cx, cy);
        @(posedge i_clk);
        @(negedge i_clk);
        i_x = 9'(cx);
        i_y = 9'(cy);
        i_wr_valid = 1'b1;
        i_wr_data = 8'h51;
        @(posedge i_clk);
        #1;
        i_wr_valid = 1'b0;
        model_apply(8'h51, stall);
        @(posedge i_clk);
        #1;
        check("rdw_old", o_chr, old);
        wait_ready(n, bb);
        check("rdw_stall", n, (stall == 0) ? 0 : stall - 1);
        @(posedge i_clk);
        #1;
        check("rdw_new", o_chr, model_read(cx, cy));
        px = cx;
        py = cy;

        // form feed, then reset 100 cycles into the clear
        @(negedge i_clk);
        i_wr_valid = 1'b1;
        i_wr_data = 8'h0C;
        @(posedge i_clk);
        #1;
        i_wr_valid = 1'b0;
        model_apply(8'h0C, stall);
        repeat (100) @(posedge i_clk);
        #1;
        check("ff_ready", o_wr_ready, 1'b0);
        check("ff_busy", o_busy, 1'b1);
        check("ff_col", o_cur_col, 6'd0);
        check("ff_row", o_cur_row, 6'd0);
        i_rst_n = 1'b0;
        #1;
        check_reset_state();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_state();
        release_and_clear();
        sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
Character-cell video memory that sits directly upstream of the 8x8 monochrome character generator. It replaces that generator's fixed character code with a per-cell code.
- Read side: takes the live pixel coordinates from the hsync/vsync counters and returns the code of the cell under the beam, with a fixed 2-cycle latency.
- Write side: a terminal-style writer with a valid/ready handshake that places characters at a cursor and handles control codes, wrap and row recycling.

Parameters:
COLS, 60, text columns (480 px / 8)
ROWS, 34, text rows (272 px / 8)
FILL_CHR, 8'h20, code used for cleared cells and off-screen reads
BLINK_W, 22, blink counter width (used only with the optional feature)

Ports:
i_clk  input  1  pixel clock (LCD_CLK domain), both sides
i_rst_n  input  1  asynchronous active-low reset
i_x  input  9  current pixel x
i_y  input  9  current pixel y
o_chr  output  8  character code for pixel (i_x,i_y), 2 cycles later
i_wr_valid  input  1  write request
i_wr_data  input  8  character or control code
o_wr_ready  output  1  writer can accept; a transfer occurs when valid & ready
o_cur_col  output  6  cursor column
o_cur_row  output  6  cursor row
o_busy  output  1  clear operation in progress

Behaviour:
- Storage: COLS*ROWS bytes, one write port and one read port, both on i_clk. Inferred block RAM with 11-bit address.
- RAM contents are undefined after reset; the CLEAR state initialises them.
- Read-during-write to the same address returns the old data.
- Read pipeline, latency exactly 2 cycles:
  - Cycle 1 registers col = i_x[8:3], row = i_y[8:3] and addr = row*COLS + col. It also registers an out-of-range flag, set when col >= COLS or row >= ROWS.
  - Cycle 2 registers o_chr: FILL_CHR if the flag is set, otherwise the RAM data.
  - o_chr is never undefined.
- Reset values: o_chr = FILL_CHR, cursor (0,0), o_wr_ready = 0, o_busy = 1. The FSM enters CLEAR.
- Writer FSM states: CLEAR, IDLE, CLRROW.
  - CLEAR:
    - Writes FILL_CHR to addresses 0..COLS*ROWS-1, one per cycle (2040 cycles at defaults).
    - ready = 0, busy = 1.
    - After the last address, goes to IDLE with cursor (0,0).
  - IDLE: ready = 1, busy = 0. On each transfer:
    - 0x20..0x7E: write the code at the cursor, then col+1. If col reaches COLS, set col = 0 and row+1.
    - 0x0D (CR): col = 0.
    - 0x0A (LF): row+1, col unchanged.
    - 0x08 (BS): col-1 if col > 0; no RAM write.
    - 0x0C (FF): cursor (0,0), go to CLEAR.
    - All other codes: ignored, but still consumed (ready stays 1).
  - Row advance (from LF or column wrap):
    - If row becomes ROWS, it wraps to 0.
    - Every row advance enters CLRROW for the new row.
  - CLRROW:
    - Writes FILL_CHR to the COLS cells of the new row.
    - ready = 0, busy = 0.
    - Returns to IDLE.
    - The cursor is already on the new row when CLRROW starts.
- At most one transfer per cycle. o_wr_ready is a registered output and may depend only on state.
- Reset asserted mid-CLEAR or mid-CLRROW: abort immediately, and restart with a full CLEAR once reset releases.

Optional Feature:
TEXT_CURSOR_EN
- Defined:
  - A free-running BLINK_W-bit counter; blink phase = counter MSB.
  - When the read cell equals (o_cur_row, o_cur_col) and blink phase = 1, o_chr = 8'h5F ('_') instead of the RAM data.
  - The comparison is pipelined so the 2-cycle latency is unchanged.
  - The counter resets to 0.
- Not defined: no counter and no cursor substitution. BLINK_W is unused.

Test Plan:
- Reset, then wait → o_busy = 1 and o_wr_ready = 0 for 2040 cycles, then ready = 1. Sweeping every cell returns 8'h20.
- Write 'H','i' (0x48, 0x69) after CLEAR → cursor (2,0). Present x=8, y=0 → o_chr = 0x69 exactly 2 cycles later; x=0 → 0x48.
- Write 60 printable chars → col wraps to 0, row = 1, and CLRROW blocks ready for 60 cycles. Cell (0,1) reads 0x20.
- With the cursor at row 33, send LF → row = 0, row 0 reads all 0x20, row 1 retains its data. Then send CR, BS at col 0, and 0x07 → cursor stays at (0,0); 0x07 is consumed with no write.
- Read x=480 (col 60) and y=272 (row 34) → o_chr = 0x20. Write and read the same address in the same cycle → old value returned.
- Send FF mid-screen, then assert reset 100 cycles into CLEAR → full CLEAR restarts on release. With TEXT_CURSOR_EN and BLINK_W=4, the cursor cell alternates between 0x5F and the stored code every 8 cycles.
